// File: rtl/pe_tile_param_if.sv
// Configuration bus bundle for pe_tile_param: address/data/strobes toward the
// tile, readback data/valid back from it.
interface pe_tile_param_if;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_we;
    logic        config_re;
    logic [31:0] config_rd_data;
    logic        config_rd_valid;

    modport master (
        output config_addr, config_data, config_we, config_re,
        input  config_rd_data, config_rd_valid
    );

    modport slave (
        input  config_addr, config_data, config_we, config_re,
        output config_rd_data, config_rd_valid
    );
endinterface

// File: rtl/pe_tile_param.sv
// Routing tile: two connection boxes feeding a registered PE, plus a switch box.
// Optional macro PE_TILE_SB_OUTREG_EN registers the switch-box outputs.
module pe_tile_param #(
    parameter int WIDTH  = 16,
    parameter int TRACKS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               tile_id,
    pe_tile_param_if.slave            cfg,
    input  logic [4*TRACKS*WIDTH-1:0] in_wires,
    output logic [4*TRACKS*WIDTH-1:0] out_wires
);
    localparam int NOUT  = 4 * TRACKS;
    localparam int BUSW  = NOUT * WIDTH;
    localparam int SELW  = $clog2(2 * TRACKS);
    localparam int NWORD = (NOUT + 15) / 16;

    logic [2:0]          op_q, op_d;
    logic [SELW-1:0]     cb0_q, cb0_d, cb1_q, cb1_d;
    logic [NWORD*32-1:0] sb_q, sb_d;
    logic [WIDTH-1:0]    acc_q, acc_d, pe_q, pe_d;
    logic [31:0]         rd_data_q, rd_data_d, rd_val_s;
    logic                rd_valid_q, rd_valid_d;

    logic                hit_s, we_s, re_s, acc_clr_s;
    logic [15:0]         blk_s;
    logic [WIDTH-1:0]    op0_s, op1_s;
    logic [BUSW-1:0]     sb_out_s;

    // Switch-box field for output o sits at flat bit 2*o (word o/16, slot o%16).
    function automatic logic [WIDTH-1:0] sb_pick(input logic [BUSW-1:0] iw,
                                                 input logic [WIDTH-1:0] pe,
                                                 input logic [1:0] sel,
                                                 input int side, input int trk);
        int src;
        if (sel == 2'd3) begin
            return pe;
        end else begin
            src = (int'(sel) < side) ? int'(sel) : int'(sel) + 1;
            return iw[(src * TRACKS + trk) * WIDTH +: WIDTH];
        end
    endfunction

    function automatic logic [WIDTH-1:0] cb_pick(input logic [BUSW-1:0] iw,
                                                 input logic [BUSW-1:0] ow,
                                                 input logic [SELW-1:0] sel,
                                                 input int side);
        int idx;
        idx = int'(sel);
        if (idx < TRACKS) begin
            return iw[(side * TRACKS + idx) * WIDTH +: WIDTH];
        end else begin
            return ow[(side * TRACKS + idx - TRACKS) * WIDTH +: WIDTH];
        end
    endfunction

    assign blk_s     = cfg.config_addr[31:16];
    assign hit_s     = (cfg.config_addr[15:0] == tile_id);
    assign we_s      = cfg.config_we && hit_s;
    assign re_s      = cfg.config_re && hit_s;
    assign acc_clr_s = we_s && (blk_s == 16'd4);

    for (genvar g = 0; g < NOUT; g++) begin : g_sb
        assign sb_out_s[g*WIDTH +: WIDTH] =
            sb_pick(in_wires, pe_q, sb_q[2*g +: 2], g / TRACKS, g % TRACKS);
    end

`ifdef PE_TILE_SB_OUTREG_EN
    logic [BUSW-1:0] out_q;

    // Registered switch-box outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= sb_out_s;
        end
    end

    assign out_wires = out_q;
`else
    assign out_wires = sb_out_s;
`endif

    // out_wires never depends on the operands, so the CB feedback ends at pe_q.
    assign op0_s = cb_pick(in_wires, out_wires, cb0_q, 0);
    assign op1_s = cb_pick(in_wires, out_wires, cb1_q, 1);

    // PE datapath and accumulator next state.
    always_comb begin
        if (acc_clr_s) begin
            acc_d = '0;
        end else if (op_q == 3'd6) begin
            acc_d = acc_q + op0_s;
        end else begin
            acc_d = acc_q;
        end
        case (op_q)
            3'd0:    pe_d = op0_s + op1_s;
            3'd1:    pe_d = op0_s - op1_s;
            3'd2:    pe_d = op0_s & op1_s;
            3'd3:    pe_d = op0_s | op1_s;
            3'd4:    pe_d = op0_s ^ op1_s;
            3'd5:    pe_d = op0_s;
            3'd6:    pe_d = acc_d;
            default: pe_d = '0;
        endcase
    end

    // Configuration register writes.
    always_comb begin
        op_d  = op_q;
        cb0_d = cb0_q;
        cb1_d = cb1_q;
        sb_d  = sb_q;
        if (we_s) begin
            case (blk_s)
                16'd4: op_d  = cfg.config_data[2:0];
                16'd5: cb1_d = cfg.config_data[SELW-1:0];
                16'd6: cb0_d = cfg.config_data[SELW-1:0];
                default: begin
                    for (int k = 0; k < NWORD; k++) begin
                        sb_d[32*k +: 32] = (blk_s == 16'(7 + k)) ? cfg.config_data
                                                                 : sb_q[32*k +: 32];
                    end
                end
            endcase
        end else begin
            sb_d = sb_q;
        end
    end

    // Readback mux, sampled from the pre-write register values.
    always_comb begin
        rd_val_s = 32'd0;
        case (blk_s)
            16'd4: rd_val_s = {29'd0, op_q};
            16'd5: rd_val_s = {{(32-SELW){1'b0}}, cb1_q};
            16'd6: rd_val_s = {{(32-SELW){1'b0}}, cb0_q};
            default: begin
                for (int k = 0; k < NWORD; k++) begin
                    rd_val_s = (blk_s == 16'(7 + k)) ? sb_q[32*k +: 32] : rd_val_s;
                end
            end
        endcase
        rd_valid_d = re_s;
        if (re_s) begin
            rd_data_d = rd_val_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q       <= 3'd0;
            cb0_q      <= '0;
            cb1_q      <= '0;
            sb_q       <= '0;
            acc_q      <= '0;
            pe_q       <= '0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            cb0_q      <= cb0_d;
            cb1_q      <= cb1_d;
            sb_q       <= sb_d;
            acc_q      <= acc_d;
            pe_q       <= pe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign cfg.config_rd_data  = rd_data_q;
    assign cfg.config_rd_valid = rd_valid_q;
endmodule
